bg_line_fetcher: RTL and testbench

- Consumer side of the scroll frame pointer. Snapshots the 13-bit FramePtr once per frame and prefetches each background scanline from the SRAM level map.
- Each line is fetched into a ping-pong line buffer during the previous line's display time.
- Serves 4-bit palette indices to the VGA colour mapper, indexed by DrawX and offset by the fine-scroll bits.
- Sits between the frame pointer register, the VGA controller and the SRAM arbiter.

---
 rtl/contra_bg_pkg.sv | 16 +
 rtl/bg_line_buffer.sv | 24 ++
 rtl/bg_line_fetcher.sv | 152 +++++++++++++++
 tb/tb_bg_line_fetcher.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/contra_bg_pkg.sv
// Shared constants and fetch-state encoding for the background line fetcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package contra_bg_pkg;
    localparam int SCREEN_W     = 640;
    localparam int PIX_PER_WORD = 4;
    localparam int MAP_WORDS    = 2048;
    localparam int LINE_WORDS   = SCREEN_W / PIX_PER_WORD + 1;
    localparam int MEM_AW       = 20;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_e;
endpackage

// File: rtl/bg_line_buffer.sv
// Ping-pong scanline store: the fetcher fills one bank while the other is displayed.
// Latency: 1 cycle from rd_addr to rd_dat.
// Backpressure: none, the write and read ports accept every cycle.
module bg_line_buffer
    import contra_bg_pkg::*;
(
    input  logic        Clk,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [7:0]  wr_addr,
    input  logic [15:0] wr_dat,
    input  logic [7:0]  rd_addr,
    output logic [15:0] rd_dat
);
    logic [15:0] mem [2][LINE_WORDS];

    // The display side always reads the bank that is not being written.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_sel][wr_addr] <= wr_dat;
        end
        rd_dat <= mem[~wr_sel][rd_addr];
    end
endmodule

// File: rtl/bg_line_fetcher.sv
// Prefetches one background scanline from the SRAM level map and serves palette indices by DrawX.
// Latency: PixelIdx is 1 cycle after DrawX; a line fetch takes LINE_WORDS accepted requests.
// Backpressure: MemReq/MemAddr are held until MemAck; a late LineStart drains the outstanding request.
module bg_line_fetcher
    import contra_bg_pkg::*;
#(
    parameter logic [MEM_AW-1:0] BG_BASE = 20'h00000
)
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [12:0]       FramePtr,
    input  logic              FrameStart,
    input  logic              LineStart,
    input  logic [8:0]        LineY,
    input  logic [9:0]        DrawX,
    output logic [3:0]        PixelIdx,
    output logic              MemReq,
    output logic [MEM_AW-1:0] MemAddr,
    input  logic              MemAck,
    input  logic [15:0]       MemData,
    output logic              Busy,
    output logic              Underrun
);
    fetch_state_e      state_q, state_d;
    logic [12:0]       fp_q;
    logic [8:0]        ly_q, ly_pend_q, ly_load;
    logic [7:0]        k_q;
    logic              wr_sel_q;
    logic              underrun_q;
    logic [1:0]        nib_q;
    logic              blank_q;

    logic              start, k_inc, wr_en, set_ur, pend_ld, last;
    logic [10:0]       col;
    logic [MEM_AW-1:0] addr;
    logic [9:0]        pix_pos;
    logic              blank;
    logic [7:0]        rd_addr;
    logic [15:0]       rd_dat;

    // Row stride is a power of two, so the row offset is a concatenation and the column wraps at 11 bits.
    assign col  = fp_q[12:2] + {3'b000, k_q};
    assign addr = BG_BASE + {ly_q, col};
    assign last = (k_q == 8'(LINE_WORDS - 1));

    // Leaving DRAIN takes the pending row unless a fresher LineStart arrives in the same cycle.
    assign ly_load = (state_q == DRAIN && !LineStart) ? ly_pend_q : LineY;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        k_inc   = 1'b0;
        wr_en   = 1'b0;
        set_ur  = 1'b0;
        pend_ld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (LineStart) begin
                    start   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (MemAck) begin
                    wr_en = 1'b1;
                    if (LineStart) begin
                        start  = 1'b1;
                        set_ur = !last;
                    end else if (last) begin
                        state_d = IDLE;
                    end else begin
                        k_inc = 1'b1;
                    end
                end else if (LineStart) begin
                    set_ur  = 1'b1;
                    pend_ld = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (MemAck) begin
                    start   = 1'b1;
                    state_d = FETCH;
                end else if (LineStart) begin
                    pend_ld = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pix_pos = DrawX + {8'b0, fp_q[1:0]};
    assign blank   = (DrawX >= 10'(SCREEN_W));
    assign rd_addr = blank ? 8'd0 : pix_pos[9:2];

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            fp_q       <= '0;
            ly_q       <= '0;
            ly_pend_q  <= '0;
            k_q        <= '0;
            wr_sel_q   <= 1'b0;
            underrun_q <= 1'b0;
            nib_q      <= '0;
            blank_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            if (FrameStart) fp_q <= FramePtr;
            if (LineStart) wr_sel_q <= ~wr_sel_q;
            if (start) begin
                ly_q <= ly_load;
                k_q  <= '0;
            end else if (k_inc) begin
                k_q <= k_q + 8'd1;
            end
            if (pend_ld) ly_pend_q <= LineY;
            if (set_ur) underrun_q <= 1'b1;
            nib_q   <= pix_pos[1:0];
            blank_q <= blank;
        end
    end

    bg_line_buffer u_buf (
        .Clk     (Clk),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel_q),
        .wr_addr (k_q),
        .wr_dat  (MemData),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    // Leftmost pixel lives in the most significant nibble.
    always_comb begin
        PixelIdx = 4'd0;
        if (!blank_q) begin
            unique case (nib_q)
                2'd0: PixelIdx = rd_dat[15:12];
                2'd1: PixelIdx = rd_dat[11:8];
                2'd2: PixelIdx = rd_dat[7:4];
                default: PixelIdx = rd_dat[3:0];
            endcase
        end
    end

    assign Busy     = (state_q != IDLE);
    assign MemReq   = Busy;
    assign MemAddr  = Busy ? addr : '0;
    assign Underrun = underrun_q;
endmodule

// File: tb/tb_bg_line_fetcher.sv
module tb_bg_line_fetcher;
    import contra_bg_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [12:0] FramePtr;
    logic        FrameStart;
    logic        LineStart;
    logic [8:0]  LineY;
    logic [9:0]  DrawX;
    logic [3:0]  PixelIdx;
    logic        MemReq;
    logic [19:0] MemAddr;
    logic        MemAck;
    logic [15:0] MemData;
    logic        Busy;
    logic        Underrun;

    always #5 Clk = ~Clk;

    bg_line_fetcher dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .FramePtr   (FramePtr),
        .FrameStart (FrameStart),
        .LineStart  (LineStart),
        .LineY      (LineY),
        .DrawX      (DrawX),
        .PixelIdx   (PixelIdx),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemAck     (MemAck),
        .MemData    (MemData),
        .Busy       (Busy),
        .Underrun   (Underrun)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] filled [LINE_WORDS];
    logic [15:0] shown  [LINE_WORDS];
    logic [12:0] fp_lat;
    int          addr_log [$];

    typedef struct {
        int drawx;
        int exp;
    } pix_vec_t;
    pix_vec_t vecs [11];

    // SRAM contents: word 0 holds 16'h1234.
    function automatic logic [15:0] mem_data(input int a);
        logic [31:0] prod;
        prod = a * 40503;
        return prod[15:0] ^ 16'h1234;
    endfunction

    function automatic int exp_addr(input int ly, input logic [12:0] fp, input int k);
        return ly * MAP_WORDS + (((int'(fp) >> 2) + k) % MAP_WORDS);
    endfunction

    function automatic int model_pix(input int x);
        int p;
        if (x >= SCREEN_W) return 0;
        p = x + int'(fp_lat[1:0]);
        return (int'(shown[p / 4]) >> (12 - 4 * (p % 4))) & 15;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic line_start(input int ly, input bit fs, input logic [12:0] fp);
        LineStart  = 1'b1;
        LineY      = 9'(ly);
        FrameStart = fs;
        FramePtr   = fp;
        step();
        LineStart  = 1'b0;
        FrameStart = 1'b0;
        if (fs) fp_lat = fp;
        shown = filled;
    endtask

    // period 0 = random acks; otherwise ack on every period-th cycle.
    task automatic fetch_line(input int ly, input int period, input int nwords, input bit jitter,
                              output int cycles);
        int k;
        bit ack;
        k = 0;
        cycles = 0;
        addr_log.delete();
        while (k < nwords && cycles < 2000) begin
            check("fetch_req", MemReq, 1);
            check("fetch_addr", MemAddr, exp_addr(ly, fp_lat, k));
            ack = (period == 0) ? ($urandom_range(0, 2) != 0) : ((cycles % period) == period - 1);
            MemAck  = ack;
            MemData = ack ? mem_data(int'(MemAddr)) : 16'($urandom);
            if (jitter) FramePtr = 13'($urandom);
            if (ack) addr_log.push_back(int'(MemAddr));
            step();
            if (ack) begin
                filled[k] = mem_data(exp_addr(ly, fp_lat, k));
                k++;
            end
            cycles++;
        end
        MemAck = 1'b0;
        check("fetch_words", k, nwords);
    endtask

    task automatic pix(input int x);
        DrawX = 10'(x);
        step();
        check("pixel", PixelIdx, model_pix(x));
    endtask

    initial begin
        int cyc;
        Reset = 1'b0; FramePtr = '0; FrameStart = 1'b0; LineStart = 1'b0; LineY = '0;
        DrawX = '0; MemAck = 1'b0; MemData = '0; fp_lat = '0;
        foreach (filled[i]) filled[i] = '0;
        shown = filled;

        vecs[0]  = '{0, 1};    vecs[1]  = '{1, 2};   vecs[2] = '{2, 3};   vecs[3] = '{3, 4};
        vecs[4]  = '{4, 8};    vecs[5]  = '{5, 12};  vecs[6] = '{6, 0};   vecs[7] = '{7, 3};
        vecs[8]  = '{8, 2};    vecs[9]  = '{640, 0}; vecs[10] = '{1023, 0};

        step(); step();
        check("rst_memreq", MemReq, 0);
        check("rst_memaddr", MemAddr, 0);
        check("rst_pixel", PixelIdx, 0);
        check("rst_busy", Busy, 0);
        check("rst_underrun", Underrun, 0);
        Reset = 1'b1;

        // Straight fetch of row 0 with an ack every cycle.
        line_start(0, 1'b1, 13'd0);
        check("t1_busy_start", Busy, 1);
        fetch_line(0, 1, LINE_WORDS, 1'b0, cyc);
        check("t1_cycles", cyc, 161);
        check("t1_busy_end", Busy, 0);
        check("t1_addr_first", addr_log[0], 0);
        check("t1_addr_last", addr_log[160], 160);
        line_start(1, 1'b0, 13'd0);
        for (int i = 0; i < 11; i++) begin
            DrawX = 10'(vecs[i].drawx);
            step();
            check("pix_table", PixelIdx, vecs[i].exp);
        end
        fetch_line(1, 1, LINE_WORDS, 1'b0, cyc);

        // Column wrap and fine scroll.
        line_start(1, 1'b1, 13'd8190);
        fetch_line(1, 1, LINE_WORDS, 1'b0, cyc);
        check("t2_addr0", addr_log[0], 4095);
        check("t2_addr1", addr_log[1], 2048);
        line_start(2, 1'b0, 13'd8190);
        DrawX = 10'd0;
        step();
        check("t2_pix0", PixelIdx, 15);
        pix(1); pix(2); pix(639);

        // Slow memory: ack every third cycle.
        fetch_line(2, 3, LINE_WORDS, 1'b0, cyc);
        check("t3_cycles", cyc, 483);
        check("t3_underrun", Underrun, 0);
        check("t3_busy", Busy, 0);

        // Random rows, scroll positions, ack patterns and FramePtr noise.
        for (int it = 0; it < 6; it++) begin
            int ly;
            ly = int'($urandom_range(0, 479));
            line_start(ly, bit'($urandom_range(0, 1)), 13'($urandom));
            pix(0); pix(639); pix(640);
            for (int j = 0; j < 5; j++) pix(int'($urandom_range(0, 1023)));
            fetch_line(ly, 0, LINE_WORDS, 1'b1, cyc);
            check("rnd_underrun", Underrun, 0);
            check("rnd_busy", Busy, 0);
        end

        // LineStart during a slow fetch, then again while draining.
        line_start(10, 1'b1, 13'd100);
        fetch_line(10, 3, 50, 1'b0, cyc);
        LineStart = 1'b1; LineY = 9'd20;
        step();
        LineStart = 1'b0;
        check("ur_busy", Busy, 1);
        check("ur_flag", Underrun, 1);
        check("ur_addr_hold", MemAddr, exp_addr(10, fp_lat, 50));
        LineStart = 1'b1; LineY = 9'd30;
        step();
        LineStart = 1'b0;
        check("ur_flag2", Underrun, 1);
        check("ur_addr_hold2", MemAddr, exp_addr(10, fp_lat, 50));
        MemAck = 1'b1; MemData = 16'hDEAD;
        step();
        MemAck = 1'b0;
        check("ur_req_kept", MemReq, 1);
        fetch_line(30, 1, LINE_WORDS, 1'b0, cyc);
        check("ur_new_addr0", addr_log[0], 30 * 2048 + 25);
        check("ur_sticky", Underrun, 1);
        check("ur_busy_end", Busy, 0);

        // Reset in the middle of a fetch.
        line_start(5, 1'b1, 13'd400);
        fetch_line(5, 1, 80, 1'b0, cyc);
        Reset = 1'b0;
        step();
        check("mr_memreq", MemReq, 0);
        check("mr_busy", Busy, 0);
        check("mr_underrun", Underrun, 0);
        check("mr_pixel", PixelIdx, 0);
        check("mr_memaddr", MemAddr, 0);
        Reset = 1'b1;
        fp_lat = '0;

        // FrameStart coincident with LineStart, then FramePtr change without FrameStart.
        line_start(7, 1'b1, 13'd1234);
        fetch_line(7, 1, LINE_WORDS, 1'b0, cyc);
        check("fs_addr0", addr_log[0], 7 * 2048 + 308);
        line_start(8, 1'b0, 13'd999);
        pix(0); pix(1); pix(2); pix(3); pix(639);
        fetch_line(8, 1, LINE_WORDS, 1'b1, cyc);
        check("fs_stale_addr0", addr_log[0], 8 * 2048 + 308);
        check("fs_underrun", Underrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
